// File: rtl/b06_irq_requester.sv
// Purpose: requester end of the interrupt handshake. It queues local events and
//   drives EQL/CONT_EQL toward the handler. It completes a 4-phase handshake on
//   ACK_IN and captures the handler status and the service latency at each ACK.
// Latency: outputs are registered. An event in cycle N raises EQL in cycle N+2.
//   A sampled ACK drops EQL on the next cycle.
// Backpressure: none toward evt_in. Events beyond 2^PEND_W-1 pending are dropped
//   and flagged on ovf_err. A request that is never acknowledged traps in ERR
//   until err_clr.
// Ports:
//   clock, nRESET_G                      clock and async active-low reset
//   evt_in, err_clr                      local event pulse, error-flag clear
//   ACK_IN, USCITE_IN, CC_MUX_IN         handler acknowledge and status
//   ENABLE_COUNT_IN                      gates latency counting
//   EQL, CONT_EQL                        request and continuation to handler
//   pending, busy                        queue depth and non-idle indication
//   status_uscite, status_ccmux          status captured at acknowledge
//   last_latency                         latency of the last served event
//   timeout_err, ovf_err                 sticky error flags
module b06_irq_requester #(
  parameter int PEND_W  = 3,
  parameter int TIMEOUT = 16,
  parameter int LAT_W   = 8
) (
  input  logic              clock,
  input  logic              nRESET_G,
  input  logic              evt_in,
  input  logic              err_clr,
  input  logic              ACK_IN,
  input  logic [1:0]        USCITE_IN,
  input  logic [1:0]        CC_MUX_IN,
  input  logic              ENABLE_COUNT_IN,
  output logic              EQL,
  output logic              CONT_EQL,
  output logic [PEND_W-1:0] pending,
  output logic              busy,
  output logic [1:0]        status_uscite,
  output logic [1:0]        status_ccmux,
  output logic [LAT_W-1:0]  last_latency,
  output logic              timeout_err,
  output logic              ovf_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_GAP,
    S_ERR
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [LAT_W-1:0]  LAT_MAX  = {LAT_W{1'b1}};
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
  // The counter holds the completed REQ cycles. A value of TIMEOUT-1 therefore
  // means that this edge ends the TIMEOUT-th cycle.
  localparam logic [LAT_W-1:0]  TMO_LAST = LAT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt;
  logic [LAT_W-1:0]  tmo_cnt;
  logic [PEND_W-1:0] pending_d;
  logic              svc_dec;
  logic              tmo_hit;
  logic              ovf_evt;

  // Pending-count bookkeeping. An event and a service on the same edge cancel out.
  always_comb begin
    svc_dec   = (state_q == S_REQ) && ACK_IN && (pending != '0);
    tmo_hit   = (state_q == S_REQ) && !ACK_IN && (tmo_cnt == TMO_LAST);
    ovf_evt   = evt_in && !svc_dec && (pending == PEND_MAX);
    pending_d = pending;
    if (evt_in && !svc_dec && !ovf_evt) begin
      pending_d = pending + PEND_ONE;
    end else if (!evt_in && svc_dec) begin
      pending_d = pending - PEND_ONE;
    end
  end

  // Next-state logic. ACK takes priority over timeout on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pending != '0) state_d = S_REQ;
      S_REQ: begin
        if (ACK_IN) begin
          state_d = S_HOLD;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_HOLD:  if (!ACK_IN) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      S_ERR:   if (err_clr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      lat_cnt       <= '0;
      tmo_cnt       <= '0;
      pending       <= '0;
      EQL           <= 1'b0;
      CONT_EQL      <= 1'b0;
      busy          <= 1'b0;
      status_uscite <= 2'b00;
      status_ccmux  <= 2'b00;
      last_latency  <= '0;
      timeout_err   <= 1'b0;
      ovf_err       <= 1'b0;
    end else begin
      pending  <= pending_d;
      // The outputs are decoded from the next state so that they line up with
      // the state register and stay free of input-to-output paths.
      EQL      <= (state_d == S_REQ);
      CONT_EQL <= (state_d == S_REQ) && (pending_d > PEND_ONE);
      busy     <= (state_d != S_IDLE);

      // The counters are held at zero outside REQ, so each request starts from zero.
      if (state_q == S_REQ) begin
        tmo_cnt <= tmo_cnt + LAT_ONE;
        if (ENABLE_COUNT_IN && (lat_cnt != LAT_MAX)) begin
          lat_cnt <= lat_cnt + LAT_ONE;
        end
      end else begin
        tmo_cnt <= '0;
        lat_cnt <= '0;
      end

      // The capture uses the count from before this edge's increment.
      if ((state_q == S_REQ) && ACK_IN) begin
        status_uscite <= USCITE_IN;
        status_ccmux  <= CC_MUX_IN;
        last_latency  <= lat_cnt;
      end

      // Setting a flag wins over clearing it, so an error on the clearing edge is kept.
      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end

      if (ovf_evt) begin
        ovf_err <= 1'b1;
      end else if (err_clr) begin
        ovf_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_b06_irq_requester.sv
module tb_b06_irq_requester;

  logic       clock = 1'b0;
  logic       nRESET_G = 1'b0;
  logic       evt_in = 1'b0;
  logic       err_clr = 1'b0;
  logic       ACK_IN = 1'b0;
  logic [1:0] USCITE_IN = 2'b00;
  logic [1:0] CC_MUX_IN = 2'b00;
  logic       ENABLE_COUNT_IN = 1'b0;
  logic       EQL, CONT_EQL, busy, timeout_err, ovf_err;
  logic [2:0] pending;
  logic [1:0] status_uscite, status_ccmux;
  logic [7:0] last_latency;

  b06_irq_requester #(.PEND_W(3), .TIMEOUT(16), .LAT_W(8)) dut (
    .clock(clock), .nRESET_G(nRESET_G), .evt_in(evt_in), .err_clr(err_clr),
    .ACK_IN(ACK_IN), .USCITE_IN(USCITE_IN), .CC_MUX_IN(CC_MUX_IN),
    .ENABLE_COUNT_IN(ENABLE_COUNT_IN), .EQL(EQL), .CONT_EQL(CONT_EQL),
    .pending(pending), .busy(busy), .status_uscite(status_uscite),
    .status_ccmux(status_ccmux), .last_latency(last_latency),
    .timeout_err(timeout_err), .ovf_err(ovf_err)
  );

  always #5 clock = ~clock;

  typedef enum int {O_EQL, O_CONT, O_PEND, O_BUSY, O_SU, O_SC, O_LAT, O_TMO, O_OVF} sig_e;
  typedef struct {
    int          due;
    sig_e        sig;
    int unsigned val;
    string       name;
  } exp_t;

  exp_t sb[$];   // expectations that fall due at a clock cycle
  exp_t rq[$];   // expectations that fall due just after reset is asserted
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int unsigned get_sig(input sig_e s);
    case (s)
      O_EQL:   return {31'd0, EQL};
      O_CONT:  return {31'd0, CONT_EQL};
      O_PEND:  return {29'd0, pending};
      O_BUSY:  return {31'd0, busy};
      O_SU:    return {30'd0, status_uscite};
      O_SC:    return {30'd0, status_ccmux};
      O_LAT:   return {24'd0, last_latency};
      O_TMO:   return {31'd0, timeout_err};
      default: return {31'd0, ovf_err};
    endcase
  endfunction

  function automatic void compare(input exp_t e);
    int unsigned got;
    got = get_sig(e.sig);
    checks++;
    if (got !== e.val) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", e.name, cyc, got, e.val);
    end
  endfunction

  // The monitor checks every expectation that is due, away from the active edge.
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        compare(sb[i]);
        sb.delete(i);
      end
    end
  end

  always @(negedge nRESET_G) begin
    #1;
    while (rq.size() > 0) compare(rq.pop_front());
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_at(input int d, input sig_e s, input int unsigned v, input string nm);
    sb.push_back('{cyc + d, s, v, nm});
  endtask

  initial begin
    // Reset state
    tick(1);
    expect_at(0, O_EQL, 0, "rst_eql");   expect_at(0, O_CONT, 0, "rst_cont");
    expect_at(0, O_PEND, 0, "rst_pend"); expect_at(0, O_BUSY, 0, "rst_busy");
    expect_at(0, O_SU, 0, "rst_su");     expect_at(0, O_SC, 0, "rst_sc");
    expect_at(0, O_LAT, 0, "rst_lat");   expect_at(0, O_TMO, 0, "rst_tmo");
    expect_at(0, O_OVF, 0, "rst_ovf");
    tick(1);
    nRESET_G = 1'b1;
    tick(2);

    // A single event, acknowledged 5 cycles after EQL rises
    evt_in = 1'b1; ENABLE_COUNT_IN = 1'b1;
    tick(1);
    evt_in = 1'b0;
    expect_at(0, O_PEND, 1, "a_pend1"); expect_at(0, O_EQL, 0, "a_eql_pre");
    expect_at(1, O_EQL, 1, "a_eql_rise"); expect_at(1, O_BUSY, 1, "a_busy");
    tick(6);
    ACK_IN = 1'b1; USCITE_IN = 2'b10; CC_MUX_IN = 2'b01;
    expect_at(1, O_EQL, 0, "a_eql_fall"); expect_at(1, O_LAT, 5, "a_latency");
    expect_at(1, O_SU, 2, "a_uscite");    expect_at(1, O_SC, 1, "a_ccmux");
    expect_at(1, O_PEND, 0, "a_pend0");   expect_at(3, O_BUSY, 1, "a_busy_gap");
    expect_at(4, O_BUSY, 0, "a_busy_idle");
    tick(2);
    ACK_IN = 1'b0; USCITE_IN = 2'b00; CC_MUX_IN = 2'b00;
    tick(4);

    // Three events back to back, ACK high for one cycle per request
    evt_in = 1'b1;
    tick(3);
    evt_in = 1'b0;
    expect_at(0, O_EQL, 1, "b_eql1");  expect_at(0, O_CONT, 1, "b_cont1");
    expect_at(0, O_PEND, 3, "b_pend3"); expect_at(1, O_EQL, 0, "b_gap1a");
    expect_at(1, O_PEND, 2, "b_pend2"); expect_at(2, O_EQL, 0, "b_gap1b");
    expect_at(3, O_EQL, 0, "b_gap1c");  expect_at(4, O_EQL, 1, "b_eql2");
    expect_at(4, O_CONT, 1, "b_cont2"); expect_at(5, O_PEND, 1, "b_pend1");
    expect_at(5, O_EQL, 0, "b_gap2a");  expect_at(6, O_EQL, 0, "b_gap2b");
    expect_at(8, O_EQL, 1, "b_eql3");   expect_at(8, O_CONT, 0, "b_cont3");
    expect_at(9, O_PEND, 0, "b_pend0"); expect_at(11, O_BUSY, 0, "b_idle");
    ACK_IN = 1'b1; tick(1); ACK_IN = 1'b0; tick(3);
    ACK_IN = 1'b1; tick(1); ACK_IN = 1'b0; tick(3);
    ACK_IN = 1'b1; tick(1); ACK_IN = 1'b0; tick(4);

    // A spurious ACK in IDLE changes nothing
    ACK_IN = 1'b1; USCITE_IN = 2'b11; CC_MUX_IN = 2'b11;
    tick(1);
    ACK_IN = 1'b0;
    expect_at(1, O_EQL, 0, "s_eql");  expect_at(1, O_BUSY, 0, "s_busy");
    expect_at(1, O_SU, 0, "s_su");    expect_at(1, O_SC, 0, "s_sc");
    expect_at(1, O_LAT, 0, "s_lat");  expect_at(1, O_PEND, 0, "s_pend");
    tick(2);

    // Latency gating: ENABLE_COUNT_IN toggles 1,0,1,0 over four REQ cycles
    evt_in = 1'b1;
    tick(1);
    evt_in = 1'b0;
    tick(1);
    ENABLE_COUNT_IN = 1'b1; tick(1);
    ENABLE_COUNT_IN = 1'b0; tick(1);
    ENABLE_COUNT_IN = 1'b1; tick(1);
    ENABLE_COUNT_IN = 1'b0;
    ACK_IN = 1'b1; USCITE_IN = 2'b01; CC_MUX_IN = 2'b10;
    expect_at(1, O_LAT, 2, "l_latency"); expect_at(1, O_SU, 1, "l_uscite");
    expect_at(1, O_SC, 2, "l_ccmux");    expect_at(1, O_PEND, 0, "l_pend");
    tick(1);
    ACK_IN = 1'b0; ENABLE_COUNT_IN = 1'b1;
    tick(4);

    // Overflow: 8 events with no ACK
    evt_in = 1'b1;
    tick(8);
    evt_in = 1'b0;
    expect_at(0, O_PEND, 7, "o_pend7"); expect_at(0, O_OVF, 1, "o_ovf_set");
    expect_at(0, O_EQL, 1, "o_eql");    expect_at(0, O_CONT, 1, "o_cont");
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    expect_at(0, O_OVF, 0, "o_ovf_clr"); expect_at(0, O_EQL, 1, "o_eql_kept");
    evt_in = 1'b1; ACK_IN = 1'b1;
    tick(1);
    evt_in = 1'b0; ACK_IN = 1'b0;
    expect_at(0, O_PEND, 7, "o_pend_same"); expect_at(0, O_OVF, 0, "o_ovf_quiet");
    expect_at(0, O_EQL, 0, "o_eql_hold");
    tick(2);
    nRESET_G = 1'b0;
    tick(1);
    nRESET_G = 1'b1;
    tick(2);

    // Asynchronous reset in the middle of a REQ
    evt_in = 1'b1;
    tick(3);
    evt_in = 1'b0;
    expect_at(0, O_EQL, 1, "r_eql_pre"); expect_at(0, O_PEND, 3, "r_pend_pre");
    tick(1);
    #2;
    rq.push_back('{0, O_EQL, 0, "r_eql_async"});
    rq.push_back('{0, O_PEND, 0, "r_pend_async"});
    rq.push_back('{0, O_BUSY, 0, "r_busy_async"});
    rq.push_back('{0, O_CONT, 0, "r_cont_async"});
    nRESET_G = 1'b0;
    #5;
    nRESET_G = 1'b1;
    tick(1);
    expect_at(0, O_EQL, 0, "r_after0"); expect_at(3, O_EQL, 0, "r_after3");
    expect_at(3, O_BUSY, 0, "r_busy_after");
    tick(4);

    // Timeout: no ACK for 16 REQ cycles
    evt_in = 1'b1;
    tick(1);
    evt_in = 1'b0;
    expect_at(16, O_EQL, 1, "t_eql_last"); expect_at(17, O_EQL, 0, "t_eql_drop");
    expect_at(17, O_TMO, 1, "t_tmo_set");  expect_at(17, O_PEND, 1, "t_pend");
    expect_at(17, O_BUSY, 1, "t_busy_err");
    tick(17);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    expect_at(0, O_TMO, 0, "t_tmo_clr"); expect_at(0, O_EQL, 0, "t_eql_idle");
    expect_at(1, O_EQL, 1, "t_eql_retry");
    tick(1);
    ACK_IN = 1'b1;
    tick(1);
    ACK_IN = 1'b0;
    expect_at(0, O_PEND, 0, "t_pend_done");
    tick(4);

    // Bounded drain: any expectation still pending here counts as a failure
    tick(4);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      failures++;
      $display("FAIL %s: expectation never reached (due %0d, now %0d)", e.name, e.due, cyc);
    end
    while (rq.size() > 0) begin
      exp_t e;
      e = rq.pop_front();
      failures++;
      $display("FAIL %s: reset expectation never reached", e.name);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/b06_irq_requester.md
Name: b06_irq_requester

Overview:
- Requester end of the interrupt-handler handshake. It queues local interrupt events and drives EQL and CONT_EQL toward the handler FSM.
- It completes a 4-phase handshake against the handler's ACKOUT, and captures the handler's USCITE/CC_MUX outputs at each acknowledge.
- It measures service latency while ENABLE_COUNT is asserted, and flags timeout and queue overflow.
- Sits beside the handler in the test/system harness as its stimulus peer.

Parameters:
- PEND_W, 3, width of the pending-event counter; max pending = 2^PEND_W-1.
- TIMEOUT, 16, REQ-state cycles without ACK before the error trap; legal range 1..2^LAT_W-1.
- LAT_W, 8, width of the latency counter and of last_latency.

Ports:
- clock  in  1  rising-edge clock.
- nRESET_G  in  1  reset; asynchronous assert, active-low.
- evt_in  in  1  one-cycle pulse = one new interrupt event.
- err_clr  in  1  clears timeout_err and ovf_err, and releases the ERR state.
- ACK_IN  in  1  handler ACKOUT.
- USCITE_IN  in  2  handler {USCITE_REG_2_, USCITE_REG_1_}.
- CC_MUX_IN  in  2  handler {CC_MUX_REG_2_, CC_MUX_REG_1_}.
- ENABLE_COUNT_IN  in  1  handler ENABLE_COUNT_REG; gates latency counting.
- EQL  out  1  request to the handler.
- CONT_EQL  out  1  continuation: further events are queued behind the current one.
- pending  out  PEND_W  queued events, including the one in service.
- busy  out  1  state != IDLE.
- status_uscite  out  2  USCITE_IN captured at ACK rise.
- status_ccmux  out  2  CC_MUX_IN captured at ACK rise.
- last_latency  out  LAT_W  latency of the last served event.
- timeout_err  out  1  sticky.
- ovf_err  out  1  sticky.

Behaviour:
- Reset (nRESET_G=0, asynchronous): state=IDLE and every register 0. All outputs are therefore 0: EQL, CONT_EQL, pending, busy, status_*, last_latency and both error flags.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, REQ, HOLD, GAP, ERR.
- IDLE:
  - If pending!=0 (value at the clock edge), go to REQ next cycle with EQL=1.
  - Clear the latency counter and the timeout counter on entry to REQ.
- REQ:
  - EQL=1; CONT_EQL=1 iff pending>=2.
  - Latency counter increments each cycle ENABLE_COUNT_IN=1 and saturates at 2^LAT_W-1.
  - Timeout counter increments every cycle.
  - On ACK_IN=1, go to HOLD. In that same edge: capture USCITE_IN to status_uscite, CC_MUX_IN to status_ccmux, and the latency counter to last_latency; decrement pending.
  - If the timeout counter reaches TIMEOUT with ACK_IN=0, go to ERR and set timeout_err. Pending is unchanged; the event is not dropped.
  - ACK wins over timeout on the same edge.
- HOLD: EQL=0, CONT_EQL=0. Wait for ACK_IN=0, then go to GAP.
- GAP: exactly one cycle with EQL=0, then IDLE. This enforces at least 2 low cycles between requests.
- ERR:
  - EQL=0, CONT_EQL=0.
  - err_clr=1 clears both flags and goes to IDLE; the stalled event is retried.
  - err_clr in any other state clears the flags only.
- Pending counter:
  - evt_in increments it; a service decrement (REQ→HOLD edge) decrements it.
  - Both on the same edge: unchanged.
  - evt_in with pending at max and no decrement on that edge: count held, ovf_err set (sticky), event dropped.
  - Never underflows; a decrement only happens when pending>=1.
- evt_in is accepted in every state, including ERR.
- ACK_IN=1 while in IDLE or GAP is ignored: no capture, no state change.

Test Plan:
- Reset mid-REQ:
  - Stimulus: evt_in x3, reach REQ, then pulse nRESET_G low for half a cycle.
  - Required: EQL, pending and busy go to 0 immediately, without waiting for a clock edge; nothing is requested after release.
- Single event with ACK delay:
  - Stimulus: evt_in at cycle 0; ENABLE_COUNT_IN=1 throughout; ACK_IN raised 5 cycles after EQL rises with USCITE_IN=2'b10, CC_MUX_IN=2'b01; ACK_IN dropped 2 cycles later.
  - Required: EQL=1 from cycle 2, falls the cycle after ACK; last_latency=5, status_uscite=2'b10, status_ccmux=2'b01, pending=0; busy drops after GAP.
- Back-to-back events:
  - Stimulus: 3 evt_in pulses; ACK_IN held high for 1 cycle per request.
  - Required: CONT_EQL=1 on the 1st and 2nd requests, 0 on the 3rd; EQL low for at least 2 cycles between requests; pending steps 3→2→1→0.
- Overflow:
  - Stimulus: PEND_W=3, 8 evt_in pulses with no ACK.
  - Required: pending=7 and ovf_err=1.
  - Follow-up: evt_in on the same edge as an ACK-driven decrement leaves pending unchanged and does not set ovf.
- Timeout:
  - Stimulus: TIMEOUT=16, evt_in, ACK_IN held 0.
  - Required: after 16 REQ cycles, EQL=0, timeout_err=1, pending=1.
  - Follow-up: err_clr pulse → flag clears and EQL re-asserts 2 cycles later.
- Latency gating:
  - Stimulus: ENABLE_COUNT_IN toggling 1,0,1,0 during 4 REQ cycles, then ACK.
  - Required: last_latency=2.
  - Also: a spurious ACK_IN pulse while IDLE changes no output.
